// File: rtl/load_store_unit.sv
// RV32 load/store unit: turns byte/half/word accesses into single-word Data_Memory
// accesses, with read-modify-write for sub-word stores and early error rejection.
module load_store_unit #(
   parameter int DEPTH_WORDS = 1024
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_we,
   input  logic [2:0]  req_funct3,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic        resp_valid,
   output logic [31:0] resp_rdata,
   output logic        resp_err,
   output logic        mem_we,
   output logic [31:0] mem_a,
   output logic [31:0] mem_wd,
   input  logic [31:0] mem_rd
);

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] RD   = 2'd1;
   localparam logic [1:0] WR   = 2'd2;
   localparam logic [1:0] RESP = 2'd3;

   localparam logic [32:0] DEPTH_L = 33'(DEPTH_WORDS);

   logic [1:0]  state;
   logic        we_q, err_q;
   logic [2:0]  funct3_q;
   logic [31:0] addr_q, wdata_q, rdata_q, merge_q;
   logic        accept, req_bad;
   logic [7:0]  lane_b;
   logic [15:0] lane_h;
   logic [31:0] extracted, merged;

   assign accept = req_valid && req_ready;

   always_comb begin
      req_bad = 1'b0;
      case (req_funct3)
         3'b000, 3'b100: req_bad = 1'b0;
         3'b001, 3'b101: req_bad = req_addr[0];
         3'b010:         req_bad = (req_addr[1:0] != 2'b00);
         default:        req_bad = 1'b1;
      endcase
      if (req_we && req_funct3[2])
         req_bad = 1'b1;
      if ({3'b000, req_addr[31:2]} >= DEPTH_L)
         req_bad = 1'b1;
   end

   // Little-endian lane selection from the word currently on mem_rd.
   assign lane_b = mem_rd[{addr_q[1:0], 3'b000} +: 8];
   assign lane_h = mem_rd[{addr_q[1], 4'b0000} +: 16];

   always_comb begin
      extracted = mem_rd;
      case (funct3_q)
         3'b000:  extracted = {{24{lane_b[7]}}, lane_b};
         3'b100:  extracted = {24'h0, lane_b};
         3'b001:  extracted = {{16{lane_h[15]}}, lane_h};
         3'b101:  extracted = {16'h0, lane_h};
         default: extracted = mem_rd;
      endcase
   end

   always_comb begin
      merged = mem_rd;
      if (funct3_q[1:0] == 2'b00)
         merged[{addr_q[1:0], 3'b000} +: 8] = wdata_q[7:0];
      else if (funct3_q[1:0] == 2'b01)
         merged[{addr_q[1], 4'b0000} +: 16] = wdata_q[15:0];
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= IDLE;
         we_q     <= 1'b0;
         err_q    <= 1'b0;
         funct3_q <= 3'b000;
         addr_q   <= 32'h0;
         wdata_q  <= 32'h0;
         rdata_q  <= 32'h0;
         merge_q  <= 32'h0;
      end else begin
         case (state)
            IDLE: if (accept) begin
               we_q     <= req_we;
               funct3_q <= req_funct3;
               addr_q   <= req_addr;
               wdata_q  <= req_wdata;
               err_q    <= req_bad;
               rdata_q  <= 32'h0;
               if (req_bad)
                  state <= RESP;
               else if (req_we && req_funct3 == 3'b010)
                  state <= WR;
               else
                  state <= RD;
            end
            RD: begin
               if (we_q) begin
                  merge_q <= merged;
                  state   <= WR;
               end else begin
                  rdata_q <= extracted;
                  state   <= RESP;
               end
            end
            WR:      state <= RESP;
            default: state <= IDLE;
         endcase
      end
   end

   // Outputs decode straight from state so an async reset drops them immediately.
   assign req_ready  = (state == IDLE);
   assign mem_we     = (state == WR);
   assign mem_a      = (state == IDLE) ? 32'h0 : {2'b00, addr_q[31:2]};
   assign mem_wd     = (state != WR) ? 32'h0 : (funct3_q == 3'b010) ? wdata_q : merge_q;
   assign resp_valid = (state == RESP);
   assign resp_err   = (state == RESP) && err_q;
   assign resp_rdata = (state == RESP && !we_q && !err_q) ? rdata_q : 32'h0;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed plus randomized bench for load_store_unit against a byte-level
// reference memory model.
module tb_load_store_unit;
   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        req_valid = 1'b0, req_we = 1'b0;
   logic [2:0]  req_funct3 = 3'b000;
   logic [31:0] req_addr = 32'h0, req_wdata = 32'h0;
   logic        req_ready, resp_valid, resp_err, mem_we;
   logic [31:0] resp_rdata, mem_a, mem_wd, mem_rd;

   logic [31:0] dmem [0:1023];
   logic [31:0] refm [0:1023];
   logic        pre_we = 1'b0;
   logic [9:0]  pre_idx = 10'd0;
   logic [31:0] pre_val = 32'h0;

   int npass = 0, ntot = 0, nfail = 0;
   logic [31:0] wa, wdv;

   load_store_unit #(.DEPTH_WORDS(1024)) dut (
      .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
      .req_we(req_we), .req_funct3(req_funct3), .req_addr(req_addr),
      .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_rdata(resp_rdata),
      .resp_err(resp_err), .mem_we(mem_we), .mem_a(mem_a), .mem_wd(mem_wd),
      .mem_rd(mem_rd));

   always #5 clk = ~clk;

   assign mem_rd = (mem_a < 32'd1024) ? dmem[mem_a[9:0]] : 32'h0;

   always @(posedge clk) begin
      if (mem_we && mem_a < 32'd1024) dmem[mem_a[9:0]] <= mem_wd;
      else if (pre_we) dmem[pre_idx] <= pre_val;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      ntot++;
      assert (obs === exp) npass++;
      else begin
         nfail++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic poke(input int idx, input logic [31:0] val);
      @(negedge clk);
      pre_we = 1'b1; pre_idx = idx[9:0]; pre_val = val;
      @(negedge clk);
      pre_we = 1'b0;
      refm[idx] = val;
   endtask

   // Reference: access width from funct3, byte-granular arithmetic on refm.
   task automatic model(input bit we, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] wd, output bit err, output logic [31:0] rd,
                        output int lat, output int nwr);
      int size, off, idx;
      longint mask, v, w;
      case (f3)
         3'd0, 3'd4: size = 1;
         3'd1, 3'd5: size = 2;
         3'd2:       size = 4;
         default:    size = 0;
      endcase
      err = (size == 0) || (we && f3 >= 3'd4) || ((a >> 2) >= 32'd1024);
      if (!err && (a % size) != 0) err = 1'b1;
      rd = 32'h0; nwr = 0; lat = 1;
      if (err) return;
      idx = int'(a >> 2);
      off = int'(a % 4);
      mask = (64'd1 << (8 * size)) - 1;
      w = longint'(refm[idx]);
      if (!we) begin
         v = (w >> (8 * off)) & mask;
         if (f3 < 3'd4 && size < 4 && v >= (mask + 1) / 2) v = v - (mask + 1);
         rd = v[31:0];
         lat = 2;
      end else begin
         w = (w & ~(mask << (8 * off))) | ((longint'(wd) & mask) << (8 * off));
         refm[idx] = w[31:0];
         lat = (size == 4) ? 2 : 3;
         nwr = 1;
      end
   endtask

   task automatic xact(input string tag, input bit we, input logic [2:0] f3,
                       input logic [31:0] a, input logic [31:0] wd);
      bit e_err, got, g_err;
      logic [31:0] e_rd, g_rd;
      int e_lat, e_nwr, lat, nwr;
      @(negedge clk);
      chk({tag, ".ready"}, {31'h0, req_ready}, 32'd1);
      req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = a; req_wdata = wd;
      @(posedge clk);
      #1 req_valid = 1'b0;
      model(we, f3, a, wd, e_err, e_rd, e_lat, e_nwr);
      lat = 0; nwr = 0; got = 1'b0; g_rd = 32'h0; g_err = 1'b0;
      while (!got && lat < 10) begin
         @(negedge clk);
         lat++;
         if (mem_we) begin nwr++; wa = mem_a; wdv = mem_wd; end
         if (resp_valid) begin got = 1'b1; g_rd = resp_rdata; g_err = resp_err; end
      end
      chk({tag, ".lat"}, 32'(lat), 32'(e_lat));
      chk({tag, ".err"}, {31'h0, g_err}, {31'h0, e_err});
      chk({tag, ".rdata"}, g_rd, e_rd);
      chk({tag, ".nwr"}, 32'(nwr), 32'(e_nwr));
      if ((a >> 2) < 32'd1024)
         chk({tag, ".mem"}, dmem[a[11:2]], refm[a[11:2]]);
   endtask

   initial begin
      int acc, resps, a1, a2;
      logic [2:0] f3;
      logic [31:0] ad;
      for (int i = 0; i < 1024; i++) refm[i] = 32'h0;

      // Reset state
      @(negedge clk);
      chk("rst.resp_valid", {31'h0, resp_valid}, 32'd0);
      chk("rst.mem_we", {31'h0, mem_we}, 32'd0);
      chk("rst.mem_a", mem_a, 32'h0);
      chk("rst.mem_wd", mem_wd, 32'h0);
      chk("rst.resp_err", {31'h0, resp_err}, 32'd0);
      rst = 1'b0;
      @(negedge clk);
      chk("rst.ready", {31'h0, req_ready}, 32'd1);

      for (int i = 0; i < 64; i++) poke(i, $urandom);
      poke(1023, $urandom);

      // Word store then word load
      xact("sw", 1'b1, 3'b010, 32'h70, 32'hDEADBEEF);
      chk("sw.wa", wa, 32'd28);
      chk("sw.wd", wdv, 32'hDEADBEEF);
      xact("lw", 1'b0, 3'b010, 32'h70, 32'h0);

      // Loads with extension
      poke(28, 32'h000080F0);
      xact("lb", 1'b0, 3'b000, 32'h70, 32'h0);
      xact("lbu", 1'b0, 3'b100, 32'h70, 32'h0);
      xact("lh", 1'b0, 3'b001, 32'h70, 32'h0);
      xact("lhu", 1'b0, 3'b101, 32'h72, 32'h0);

      // Sub-word stores
      poke(28, 32'h11223344);
      xact("sb", 1'b1, 3'b000, 32'h71, 32'hFFFFFFAA);
      chk("sb.word", dmem[28], 32'h1122AA44);
      xact("sh", 1'b1, 3'b001, 32'h72, 32'h1234BEEF);
      chk("sh.word", dmem[28], 32'hBEEFAA44);

      // Errors
      xact("e_lw_mis", 1'b0, 3'b010, 32'h72, 32'h0);
      xact("e_lh_mis", 1'b0, 3'b001, 32'h71, 32'h0);
      xact("e_sbu", 1'b1, 3'b100, 32'h70, 32'h99);
      xact("e_range", 1'b0, 3'b010, 32'h1000, 32'h0);
      xact("e_f3", 1'b0, 3'b011, 32'h70, 32'h0);
      xact("last_word", 1'b0, 3'b010, 32'hFFC, 32'h0);

      // Reset in the middle of a word store's write cycle
      poke(28, 32'h12345678);
      @(negedge clk);
      req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b010; req_addr = 32'h70; req_wdata = 32'h55;
      @(posedge clk);
      #1 req_valid = 1'b0;
      @(negedge clk);
      chk("rstmid.we_before", {31'h0, mem_we}, 32'd1);
      #1 rst = 1'b1;
      #1;
      chk("rstmid.we_after", {31'h0, mem_we}, 32'd0);
      chk("rstmid.mem_wd", mem_wd, 32'h0);
      @(posedge clk);
      @(negedge clk) rst = 1'b0;
      @(negedge clk);
      chk("rstmid.ready", {31'h0, req_ready}, 32'd1);
      chk("rstmid.word", dmem[28], 32'h12345678);

      // Request held valid across two back-to-back loads
      req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'b010; req_addr = 32'h70;
      acc = 0; resps = 0; a1 = -1; a2 = -1;
      for (int c = 0; c < 10; c++) begin
         if (req_valid && req_ready) begin
            if (acc == 0) a1 = c; else a2 = c;
            acc++;
         end
         if (resp_valid) begin
            resps++;
            chk("stall.rdata", resp_rdata, refm[28]);
         end
         @(posedge clk);
         #1 if (acc == 2) req_valid = 1'b0;
         @(negedge clk);
      end
      chk("stall.accepts", 32'(acc), 32'd2);
      chk("stall.gap", 32'(a2 - a1), 32'd3);
      chk("stall.resps", 32'(resps), 32'd2);

      // Randomized traffic
      for (int i = 0; i < 300; i++) begin
         f3 = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(0, 7))
                                           : 3'(($urandom_range(0, 4) == 3) ? 4 :
                                                ($urandom_range(0, 4) == 4) ? 5 : $urandom_range(0, 2));
         case ($urandom_range(0, 19))
            0:       ad = 32'h1000 + 32'($urandom_range(0, 255));
            1:       ad = $urandom | 32'h80000000;
            default: ad = {24'h0, 6'($urandom_range(0, 63)), 2'($urandom_range(0, 3))};
         endcase
         xact("rand", 1'($urandom_range(0, 1)), f3, ad, $urandom);
      end

      $display("%0d/%0d checks passed", npass, ntot);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog timeout");
      $fatal(1, "timeout");
   end
endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- Sits between the pipeline MEM stage and the word-addressed Data_Memory. Converts RV32 byte, halfword and word loads/stores into word accesses.
- Sub-word stores are done as read-modify-write. Load results are sign- or zero-extended.
- Misaligned, out-of-range and illegal accesses are flagged; they never touch memory.
- Request/response handshake; the pipeline stalls while the unit is busy.

Parameters:
DEPTH_WORDS, 1024, number of 32-bit words in Data_Memory; valid word index is 0..DEPTH_WORDS-1

Ports:
clk  input  1  clock, all state updates on rising edge
rst  input  1  asynchronous, active-high reset
req_valid  input  1  request present from MEM stage
req_ready  output  1  unit can accept a request (high only in IDLE)
req_we  input  1  1 = store, 0 = load
req_funct3  input  3  RV32 funct3: 000 B, 001 H, 010 W, 100 BU, 101 HU
req_addr  input  32  byte address
req_wdata  input  32  store data (low byte/half used for B/H)
resp_valid  output  1  one-cycle pulse, access complete
resp_rdata  output  32  extended load data (0 for stores and errors)
resp_err  output  1  valid with resp_valid: misaligned, out-of-range or illegal funct3
mem_we  output  1  Data_Memory write enable
mem_a  output  32  Data_Memory word index = {2'b00, addr_q[31:2]}
mem_wd  output  32  Data_Memory write data
mem_rd  input  32  Data_Memory combinational read data at mem_a

Behaviour:
- Request capture
  - Handshake: transfer when req_valid && req_ready at a rising edge.
  - On transfer, latch we_q, funct3_q, addr_q and wdata_q.
  - req_ready = (state == IDLE).
- FSM states: IDLE, RD, WR, RESP.
  - IDLE, accept with error -> RESP, err_q=1, no memory access.
  - IDLE, accept load or sub-word store -> RD.
  - IDLE, accept word store -> WR.
  - RD, load -> RESP. rdata_q = extract(mem_rd) at the edge.
  - RD, store -> WR. merge_q = mem_rd with the selected byte/half replaced by wdata_q low bits at the edge.
  - WR -> RESP. mem_we=1 for exactly this cycle. mem_wd = merge_q (sub-word) or wdata_q (word).
  - RESP -> IDLE. resp_valid=1 for exactly this cycle; resp_rdata = rdata_q (loads), else 0; resp_err = err_q.
- Error conditions (any one sets err_q)
  - H/HU with addr[0]=1.
  - W with addr[1:0]!=0.
  - funct3 in {011, 110, 111}.
  - Store with funct3 100 or 101.
  - addr[31:2] >= DEPTH_WORDS.
- Latency, counted from the accept edge
  - Load: 2 cycles to resp_valid.
  - Word store: 2 cycles.
  - Sub-word store: 3 cycles.
  - Error: 1 cycle.
- Extraction (little-endian)
  - Byte lane = addr_q[1:0]; half lane = addr_q[1].
  - B and H sign-extend from bit 7/15. BU and HU zero-extend. W passes the word through.
- Merge
  - Only the addressed lane changes; the other bytes are preserved from mem_rd.
- mem_a: driven from addr_q in all states; mem_a = 0 in IDLE.
- mem_wd: 0 when mem_we=0.
- Reset
  - Async: state=IDLE, every output register 0.
  - mem_we, resp_valid and resp_err drop immediately, even mid-WR; the pending write is abandoned.
  - req_ready=1 after reset deasserts.
- A request held on req_valid while busy is not consumed; it is accepted in the first IDLE cycle.
- Back-to-back requests are allowed: RESP -> IDLE -> accept the next request.

Test Plan:
- Word store then word load: SW 0xDEADBEEF at addr 0x70; LW 0x70 -> mem_we one cycle with mem_a=28, mem_wd=0xDEADBEEF; load resp_rdata=0xDEADBEEF, resp_err=0, 2 cycles after accept.
- Byte loads with extension: word 28 preset to 0x000080F0. LB 0x70 -> 0xFFFFFFF0; LBU 0x70 -> 0x000000F0; LH 0x70 -> 0xFFFF80F0; LHU 0x72 -> 0x00000000.
- Sub-word store preserves neighbours: word 28 = 0x11223344. SB 0xAA at 0x71 -> word 0x1122AA44. SH 0xBEEF at 0x72 -> 0xBEEFAA44. resp_valid 3 cycles after accept.
- Errors: LW at 0x72; LH at 0x71; SB with funct3=100; LW at 0x1000 (index 1024) -> resp_err=1 after 1 cycle, mem_we never asserted, memory unchanged.
- Reset mid-operation: assert rst during WR of SW 0x55 to 0x70 -> mem_we falls the same cycle, word 28 unchanged, req_ready=1 after release.
- Handshake under stall: req_valid held high across two back-to-back LW requests -> second accepted only on its IDLE cycle; exactly two resp_valid pulses.
